// File: rtl/shift_pkg.sv
// Shared operation and state encodings for the chunked shift sequencer.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-chunk shifter: shifts data by k (0..STEP) per op.
module shift_step
  import shift_pkg::*;
#(
  parameter int L1   = 8,
  parameter int STEP = 4,
  localparam int KW  = $clog2(STEP + 1)
) (
  input  logic [L1-1:0] data,
  input  logic [1:0]    op,
  input  logic [KW-1:0] k,
  output logic [L1-1:0] out
);

  // Rotation via a doubled word: the upper half after a left shift is the rotated value.
  logic [2*L1-1:0] rot;
  assign rot = {data, data} << k;

  always_comb begin
    out = data;
    case (op)
      OP_SLL:  out = data << k;
      OP_SRL:  out = data >> k;
      OP_SRA:  out = $signed(data) >>> k;
      OP_ROL:  out = rot[2*L1-1:L1];
      default: out = data;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: applies any shift amount in chunks of at most
// STEP bits per clock through one shared shift_step, with valid/ready on both sides.
module shift_seq
  import shift_pkg::*;
#(
  parameter int L1   = 8,
  parameter int L2   = 8,
  parameter int STEP = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [L1-1:0] in1,
  input  logic [L2-1:0] in2,
  input  logic [1:0]    op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [L1-1:0] out,
  output logic          busy
);

  localparam int LW = $clog2(L1);
  localparam int RW = max_int(L2, LW + 1);
  localparam int KW = $clog2(STEP + 1);
  localparam logic [RW-1:0] L1_R   = RW'(L1);
  localparam logic [RW-1:0] STEP_R = RW'(STEP);

  state_t          state_reg;
  logic [L1-1:0]   data_reg;
  logic [RW-1:0]   rem_reg;
  logic [1:0]      op_reg;

  logic [RW-1:0]   in2_w;
  logic [RW-1:0]   eff;
  logic [KW-1:0]   k;
  logic [L1-1:0]   step_out;

  assign in2_w = RW'(in2);

  // Linear shifts saturate at L1 (all fill bits); rotation only cares about in2 mod L1.
  always_comb begin
    if (op == OP_ROL) begin
      eff = RW'(in2[LW-1:0]);
    end else begin
      eff = (in2_w > L1_R) ? L1_R : in2_w;
    end
  end

  assign k = (rem_reg > STEP_R) ? KW'(STEP) : KW'(rem_reg);

  shift_step #(
    .L1   (L1),
    .STEP (STEP)
  ) u_step (
    .data (data_reg),
    .op   (op_reg),
    .k    (k),
    .out  (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      data_reg  <= '0;
      rem_reg   <= '0;
      op_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            data_reg  <= in1;
            op_reg    <= op;
            rem_reg   <= eff;
            state_reg <= (eff == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          data_reg <= step_out;
          rem_reg  <= rem_reg - RW'(k);
          if (rem_reg <= STEP_R) begin
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);
  assign busy      = (state_reg == S_SHIFT) || (state_reg == S_DONE);
  assign out       = data_reg;

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle sequencer that time-shares one small shift-step datapath.
- Shift amounts of any size are applied in chunks of at most STEP bits per clock, so the design does not need a full-width barrel shifter.
- Supports logical left, logical right, arithmetic right and rotate left.
- Sits between an operand producer and a consumer, with valid/ready handshakes on both sides.

Parameters:
- L1, 8: data width in bits; must be a power of two and at least 2.
- L2, 8: shift-amount input width in bits.
- STEP, 4: maximum shift applied per SHIFT cycle; range 1 to L1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  request can be accepted; high only in IDLE.
- in1  input  L1  operand data.
- in2  input  L2  shift amount, unsigned.
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- out  output  L1  result data.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state forced to IDLE; data register, remaining counter and op register cleared to 0.
  - out=0, out_valid=0, busy=0, in_ready=1 (decoded from IDLE).
  - Reset mid-operation abandons the operation; no partial result is presented.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). out is the data register; it is held stable while in DONE.
- Accept: a request is accepted on a rising edge where in_valid and in_ready are both high.
  - On accept, in1, op and the effective amount eff are latched.
  - eff = min(in2, L1) for SLL, SRL and SRA; eff = in2 mod L1 (low log2(L1) bits) for ROL.
  - Next state is DONE if eff==0, otherwise SHIFT.
- SHIFT, each cycle:
  - k = min(rem, STEP); data register <= step(data, op, k); rem <= rem-k.
  - If rem <= STEP the next state is DONE, otherwise stay in SHIFT.
- Latency: out_valid rises ceil(eff/STEP) edges after the accepting edge. For eff==0, out_valid is high right after the accepting edge.
- DONE: hold until out_ready is high at a rising edge, then go to IDLE. There is no bypass: a new request can be accepted no earlier than the edge after leaving DONE, giving a minimum of 1 IDLE cycle between operations.
- Arithmetic and fill rules:
  - SLL: zero fill on the right.
  - SRL: zero fill on the left.
  - SRA: fill with the original bit L1-1, which stays invariant across chunks.
  - ROL: wraps bits around. Shift amounts of L1 or more therefore give all zeros for SLL/SRL and all sign bits for SRA.
- Signal stability: in1, in2 and op are ignored unless accepted; changes while busy have no effect. out_ready is ignored outside DONE.
- Counter: rem is max(L2, log2(L1)+1) bits wide, so clamping never overflows.

Decomposition:
- Shared package/header shift_pkg:
  - op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROL=2'b11.
  - state encodings S_IDLE, S_SHIFT, S_DONE.
- Sub-module shift_step (combinational): inputs data[L1], op, k in 0..STEP; output is data shifted by k per the op rules. It is instantiated once in shift_seq and is separately testable.
- shift_seq holds the FSM, operand registers, clamp/modulo logic and counter.

Test Plan (L1=8, L2=8, STEP=4 unless stated):
- SLL, in1=0x81, in2=3: expect out=0x08, out_valid 1 edge after accept, in_ready=0 until the DONE handshake completes.
- SRA, in1=0x90, in2=9: eff clamps to 8, expect out=0xFF, 2 edges after accept. SRL, in1=0x90, in2=200: expect out=0x00, 2 edges after accept.
- ROL, in1=0x81, in2=13: eff=5, expect out=0x30, 2 edges after accept. SRL, in1=0xF0, in2=0: expect out=0xF0, out_valid right after the accepting edge.
- Backpressure: hold out_ready=0 for 3 cycles in DONE; out stays constant, busy=1, in_valid is ignored. Raise out_ready: expect IDLE next edge, then a back-to-back request is accepted.
- Reset mid-SHIFT: SLL 0xFF by 8, assert rst_n=0 asynchronously after 1 SHIFT cycle. Expect out=0, out_valid=0, busy=0 immediately; the next request after release completes normally.
- STEP=1 build: SRA, in1=0x80, in2=7: expect out=0xFF after 7 edges. Random sweep of all op/in1/in2 combinations against a golden model.
